// File: rtl/data_bus_if_if.sv
// Wishbone classic bus bundle between the data-memory bridge (master)
// and a system bus slave.
//   adr     : byte address, master -> slave
//   dat_m2s : store data, master -> slave
//   sel     : byte enables, master -> slave
//   we      : 1 = write, master -> slave
//   stb/cyc : strobe / cycle valid, master -> slave
//   dat_s2m : read data, slave -> master
//   ack     : cycle acknowledge, slave -> master
interface data_bus_if_if;
    logic [31:0] adr;
    logic [31:0] dat_m2s;
    logic [3:0]  sel;
    logic        we;
    logic        stb;
    logic        cyc;
    logic [31:0] dat_s2m;
    logic        ack;

    modport master (
        output adr, dat_m2s, sel, we, stb, cyc,
        input  dat_s2m, ack
    );

    modport slave (
        input  adr, dat_m2s, sel, we, stb, cyc,
        output dat_s2m, ack
    );
endinterface

// File: rtl/data_bus_if.sv
// Wishbone master bridge for the CPU data-memory port. Each single-cycle
// CPU access becomes one Wishbone classic cycle; the pipeline is held via
// o_stallreq until the slave acks, and read data is kept in r_rd_buf while
// the pipeline is still stalled for other reasons.
//
// Ports:
//   i_clk       : clock, all state on rising edge
//   i_rst_n     : asynchronous active-low reset
//   i_stall     : 6-bit pipeline stall vector from ctrl
//   i_flush     : pipeline flush, aborts any access
//   i_cpu_ce    : CPU access request
//   i_cpu_we    : 1 = store
//   i_cpu_addr  : byte address
//   i_cpu_sel   : byte enables
//   i_cpu_data  : store data
//   o_cpu_data  : load data to the CPU
//   o_stallreq  : stall request to ctrl
//   wb          : Wishbone master side
//
// state   | meaning
// --------+-----------------------------------------------------
// IDLE    | no bus cycle in progress
// BUSY    | bus cycle in progress, waiting for ack
// WAIT    | cycle done, pipeline still stalled, data in r_rd_buf
module data_bus_if (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [5:0]             i_stall,
    input  logic                   i_flush,
    input  logic                   i_cpu_ce,
    input  logic                   i_cpu_we,
    input  logic [31:0]            i_cpu_addr,
    input  logic [3:0]             i_cpu_sel,
    input  logic [31:0]            i_cpu_data,
    output logic [31:0]            o_cpu_data,
    output logic                   o_stallreq,
    data_bus_if_if.master          wb
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [31:0] r_wb_adr;
    logic [31:0] r_wb_dat;
    logic [3:0]  r_wb_sel;
    logic        r_wb_we;
    logic        r_wb_stb;
    logic        r_wb_cyc;
    logic [31:0] r_rd_buf;

    logic        w_start;

    assign w_start = i_cpu_ce && !i_flush;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start) w_state_nxt = ST_BUSY;
            end
            ST_BUSY: begin
                // flush wins over a coincident ack: the access is abandoned
                if (i_flush)
                    w_state_nxt = ST_IDLE;
                else if (wb.ack)
                    w_state_nxt = (i_stall != 6'd0) ? ST_WAIT : ST_IDLE;
            end
            ST_WAIT: begin
                if (i_flush || (i_stall == 6'd0)) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        o_stallreq = 1'b0;
        o_cpu_data = 32'd0;
        case (r_state)
            ST_IDLE: begin
                o_stallreq = w_start;
                o_cpu_data = r_rd_buf;
            end
            ST_BUSY: begin
                o_stallreq = !wb.ack && !i_flush;
                // forward the load data in the ack cycle so the pipeline
                // can advance on this edge
                if (wb.ack && !r_wb_we) o_cpu_data = wb.dat_s2m;
            end
            ST_WAIT: begin
                o_cpu_data = r_rd_buf;
            end
            default: ;
        endcase
    end

    // Bus outputs are registered so an async reset drops them at once.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wb_adr <= 32'd0;
            r_wb_dat <= 32'd0;
            r_wb_sel <= 4'd0;
            r_wb_we  <= 1'b0;
            r_wb_stb <= 1'b0;
            r_wb_cyc <= 1'b0;
            r_rd_buf <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_wb_adr <= i_cpu_addr;
                        r_wb_dat <= i_cpu_data;
                        r_wb_sel <= i_cpu_sel;
                        r_wb_we  <= i_cpu_we;
                        r_wb_stb <= 1'b1;
                        r_wb_cyc <= 1'b1;
                        r_rd_buf <= 32'd0;
                    end
                end
                ST_BUSY: begin
                    if (i_flush || wb.ack) begin
                        r_wb_adr <= 32'd0;
                        r_wb_dat <= 32'd0;
                        r_wb_sel <= 4'd0;
                        r_wb_we  <= 1'b0;
                        r_wb_stb <= 1'b0;
                        r_wb_cyc <= 1'b0;
                        r_rd_buf <= i_flush ? 32'd0 : wb.dat_s2m;
                    end
                end
                ST_WAIT: begin
                    if (i_flush) r_rd_buf <= 32'd0;
                end
                default: ;
            endcase
        end
    end

    assign wb.adr     = r_wb_adr;
    assign wb.dat_m2s = r_wb_dat;
    assign wb.sel     = r_wb_sel;
    assign wb.we      = r_wb_we;
    assign wb.stb     = r_wb_stb;
    assign wb.cyc     = r_wb_cyc;

endmodule

// File: tb/tb_data_bus_if.sv
// Directed bench for data_bus_if. Inputs change on the falling edge and
// outputs are sampled 1 ns later, so each sample shows the state after the
// previous rising edge together with the current inputs.
module tb_data_bus_if;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [5:0]  stall;
   logic        flush;
   logic        cpu_ce;
   logic        cpu_we;
   logic [31:0] cpu_addr;
   logic [3:0]  cpu_sel;
   logic [31:0] cpu_wdata;
   logic [31:0] cpu_rdata;
   logic        stallreq;

   int n_checks = 0;
   int n_fail   = 0;

   data_bus_if_if wb ();

   data_bus_if dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_stall    (stall),
      .i_flush    (flush),
      .i_cpu_ce   (cpu_ce),
      .i_cpu_we   (cpu_we),
      .i_cpu_addr (cpu_addr),
      .i_cpu_sel  (cpu_sel),
      .i_cpu_data (cpu_wdata),
      .o_cpu_data (cpu_rdata),
      .o_stallreq (stallreq),
      .wb         (wb.master)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      logic [31:0] b2b_addr [4];
      logic [31:0] b2b_data [4];
      int          cyc_pulses;

      rst_n = 1'b0; stall = 6'd0; flush = 1'b0;
      cpu_ce = 1'b0; cpu_we = 1'b0; cpu_addr = 32'd0; cpu_sel = 4'd0; cpu_wdata = 32'd0;
      wb.ack = 1'b0; wb.dat_s2m = 32'd0;
      #1;
      chk("rst_stb", wb.stb, 1'b0);
      chk("rst_cyc", wb.cyc, 1'b0);
      chk("rst_adr", wb.adr, 32'd0);
      chk("rst_stallreq", stallreq, 1'b0);
      chk("rst_rdata", cpu_rdata, 32'd0);
      tick(); rst_n = 1'b1;

      // zero-wait read
      tick();
      cpu_ce = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0040; cpu_sel = 4'hF;
      #1;
      chk("zw_stallreq_req", stallreq, 1'b1);
      chk("zw_stb_pre", wb.stb, 1'b0);
      tick();
      stall = 6'b000011; wb.ack = 1'b1; wb.dat_s2m = 32'hDEAD_BEEF;
      #1;
      chk("zw_stb", wb.stb, 1'b1);
      chk("zw_adr", wb.adr, 32'h0000_0040);
      chk("zw_sel", wb.sel, 4'hF);
      chk("zw_stallreq_ack", stallreq, 1'b0);
      chk("zw_rdata_fwd", cpu_rdata, 32'hDEAD_BEEF);
      stall = 6'd0;
      tick();
      cpu_ce = 1'b0; wb.ack = 1'b0; wb.dat_s2m = 32'd0;
      #1;
      chk("zw_stb_after", wb.stb, 1'b0);
      chk("zw_cyc_after", wb.cyc, 1'b0);
      chk("zw_rdata_buf", cpu_rdata, 32'hDEAD_BEEF);

      // 3-wait write
      tick();
      cpu_ce = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h0000_0100; cpu_sel = 4'b0011;
      cpu_wdata = 32'h1234_5678;
      #1;
      chk("wr_stallreq_req", stallreq, 1'b1);
      for (int i = 0; i < 4; i++) begin
         tick();
         stall = 6'b000011;
         wb.ack = (i == 3);
         #1;
         chk("wr_stb", wb.stb, 1'b1);
         chk("wr_we", wb.we, 1'b1);
         chk("wr_adr", wb.adr, 32'h0000_0100);
         chk("wr_dat", wb.dat_m2s, 32'h1234_5678);
         chk("wr_sel", wb.sel, 4'b0011);
         chk("wr_stallreq", stallreq, (i != 3));
      end
      stall = 6'd0;
      tick();
      cpu_ce = 1'b0; cpu_we = 1'b0; wb.ack = 1'b0;
      #1;
      chk("wr_stb_after", wb.stb, 1'b0);
      chk("wr_we_after", wb.we, 1'b0);
      chk("wr_sel_after", wb.sel, 4'd0);
      chk("wr_adr_after", wb.adr, 32'd0);

      // read with external stall after the ack
      tick();
      cpu_ce = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0200; cpu_sel = 4'hF;
      #1;
      chk("st_stallreq_req", stallreq, 1'b1);
      tick();
      stall = 6'b001111; wb.ack = 1'b1; wb.dat_s2m = 32'hCAFE_0001;
      #1;
      chk("st_rdata_fwd", cpu_rdata, 32'hCAFE_0001);
      chk("st_stallreq_ack", stallreq, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         wb.ack = 1'b0; wb.dat_s2m = 32'h0BAD_0BAD;
         #1;
         chk("st_wait_stb", wb.stb, 1'b0);
         chk("st_wait_stallreq", stallreq, 1'b0);
         chk("st_wait_rdata", cpu_rdata, 32'hCAFE_0001);
      end
      tick();
      stall = 6'd0; cpu_ce = 1'b0;
      #1;
      chk("st_release_stb", wb.stb, 1'b0);
      tick();
      #1;
      chk("st_idle_stb", wb.stb, 1'b0);
      chk("st_idle_rdata", cpu_rdata, 32'hCAFE_0001);

      // request while flushing in IDLE is ignored
      tick();
      cpu_ce = 1'b1; flush = 1'b1; cpu_addr = 32'h0000_0280;
      #1;
      chk("fi_stallreq", stallreq, 1'b0);
      tick();
      cpu_ce = 1'b0; flush = 1'b0;
      #1;
      chk("fi_stb", wb.stb, 1'b0);

      // flush in BUSY with coincident ack
      tick();
      cpu_ce = 1'b1; cpu_addr = 32'h0000_0300;
      #1;
      chk("fl_stallreq_req", stallreq, 1'b1);
      tick();
      flush = 1'b1; wb.ack = 1'b1; wb.dat_s2m = 32'h55AA_55AA;
      #1;
      chk("fl_stb_busy", wb.stb, 1'b1);
      chk("fl_stallreq", stallreq, 1'b0);
      tick();
      flush = 1'b0; cpu_ce = 1'b0; wb.ack = 1'b0; wb.dat_s2m = 32'd0;
      #1;
      chk("fl_stb_after", wb.stb, 1'b0);
      chk("fl_cyc_after", wb.cyc, 1'b0);
      chk("fl_rdbuf", cpu_rdata, 32'd0);
      chk("fl_stallreq_after", stallreq, 1'b0);

      // async reset mid-cycle
      tick();
      cpu_ce = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h0000_0400; cpu_sel = 4'b1100;
      cpu_wdata = 32'hA5A5_0F0F;
      tick();
      #1;
      chk("ar_stb_busy", wb.stb, 1'b1);
      #1;
      rst_n = 1'b0; cpu_ce = 1'b0; cpu_we = 1'b0;
      #1;
      chk("ar_stb", wb.stb, 1'b0);
      chk("ar_cyc", wb.cyc, 1'b0);
      chk("ar_we", wb.we, 1'b0);
      chk("ar_adr", wb.adr, 32'd0);
      chk("ar_dat", wb.dat_m2s, 32'd0);
      chk("ar_sel", wb.sel, 4'd0);
      chk("ar_stallreq", stallreq, 1'b0);
      chk("ar_rdata", cpu_rdata, 32'd0);
      tick(); rst_n = 1'b1;

      // back-to-back loads, slave acks in the first stb cycle
      b2b_addr[0] = 32'h0000_0010; b2b_data[0] = 32'h1111_0000;
      b2b_addr[1] = 32'h0000_0020; b2b_data[1] = 32'h2222_0001;
      b2b_addr[2] = 32'h0000_0010; b2b_data[2] = 32'h3333_0002;
      b2b_addr[3] = 32'h0000_0020; b2b_data[3] = 32'h4444_0003;
      cyc_pulses = 0;
      for (int k = 0; k < 4; k++) begin
         tick();
         cpu_ce = 1'b1; cpu_we = 1'b0; cpu_sel = 4'hF; cpu_addr = b2b_addr[k];
         wb.ack = 1'b0; wb.dat_s2m = 32'd0;
         #1;
         chk("bb_gap_cyc", wb.cyc, 1'b0);
         chk("bb_stallreq_req", stallreq, 1'b1);
         tick();
         wb.ack = 1'b1; wb.dat_s2m = b2b_data[k];
         #1;
         if (wb.cyc === 1'b1) cyc_pulses++;
         chk("bb_adr", wb.adr, b2b_addr[k]);
         chk("bb_rdata", cpu_rdata, b2b_data[k]);
         chk("bb_stallreq_ack", stallreq, 1'b0);
      end
      tick();
      cpu_ce = 1'b0; wb.ack = 1'b0;
      #1;
      chk("bb_pulses", cyc_pulses, 32'd4);
      chk("bb_final_cyc", wb.cyc, 1'b0);
      chk("bb_final_rdata", cpu_rdata, 32'h4444_0003);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
